// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - serial sample input and parallel frame output bundle for tdm_demux4
interface tdm_demux4_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0]   din;
   logic               din_valid;
   logic               sync;
   logic [4*WIDTH-1:0] w;
   logic               frame_valid;
   logic               locked;
   logic [1:0]         slot;
   logic               sync_err;

   modport master (
      output din, din_valid, sync,
      input  w, frame_valid, locked, slot, sync_err
   );

   modport slave (
      input  din, din_valid, sync,
      output w, frame_valid, locked, slot, sync_err
   );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot round-robin TDM demultiplexer with sync-marker lock.
// Optional strict lost-sync detection at slot 0: TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux4 #(
   parameter int WIDTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   tdm_demux4_if.slave  bus
);
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [1:0]         slot_q, slot_d;
   logic [WIDTH-1:0]   sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
   logic [4*WIDTH-1:0] w_q, w_d;
   logic               fv_q, fv_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   din;

   assign din = bus.din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HUNT;
         slot_q  <= 2'd0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         w_q     <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         w_q     <= w_d;
         fv_q    <= fv_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      w_d     = w_q;
      fv_d    = 1'b0;
      err_d   = 1'b0;
      if (bus.din_valid) begin
         if (state_q == HUNT) begin
            if (bus.sync) begin
               sh0_d   = din;
               slot_d  = 2'd1;
               state_d = LOCKED;
            end
         end else if (bus.sync && slot_q != 2'd0) begin
            // Early sync restarts the frame; older shadow slots get overwritten before use
            err_d  = 1'b1;
            sh0_d  = din;
            slot_d = 2'd1;
         end else if (!bus.sync && slot_q == 2'd0) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            err_d   = 1'b1;
            state_d = HUNT;
            slot_d  = 2'd0;
`else
            sh0_d  = din;
            slot_d = 2'd1;
`endif
         end else begin
            slot_d = slot_q + 2'd1;
            case (slot_q)
               2'd0:    sh0_d = din;
               2'd1:    sh1_d = din;
               2'd2:    sh2_d = din;
               default: begin
                  w_d  = {din, sh2_q, sh1_q, sh0_q};
                  fv_d = 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.w           = w_q;
   assign bus.frame_valid = fv_q;
   assign bus.locked      = (state_q == LOCKED);
   assign bus.slot        = slot_q;
   assign bus.sync_err    = err_q;
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer: the receive end of a 4-slot round-robin channel mux.
- Takes one serial stream of WIDTH-bit samples, one slot per accepted sample, with a sync marker on slot 0.
- Rebuilds the 4 parallel channel words and presents them as one registered frame with a one-cycle strobe.
- Sits after a serial/TDM link and feeds 4-channel parallel logic.

Parameters:
- WIDTH, 1, bits per channel sample.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- din  input  WIDTH  serial sample
- din_valid  input  1  din carries a sample this cycle
- sync  input  1  marks the current sample as slot 0; only qualified by din_valid
- w  output  4*WIDTH  frame register; channel k occupies w[k*WIDTH +: WIDTH]
- frame_valid  output  1  one-cycle pulse: w was updated at the preceding edge
- locked  output  1  1 while in LOCKED
- slot  output  2  slot index the next accepted sample will fill
- sync_err  output  1  one-cycle pulse on a sync violation

Behaviour:
- Reset (async, any time, including mid-frame):
  - w=0, frame_valid=0, locked=0, slot=0, sync_err=0.
  - Shadow registers cleared; state=HUNT; any partial frame is discarded.
- "Accepted" means din_valid=1 at a rising clk edge. A cycle with din_valid=0 changes nothing except clearing the pulse outputs.
- HUNT:
  - Accepted samples with sync=0 are dropped.
  - Accepted sample with sync=1 is stored to shadow[0]; slot<=1; state<=LOCKED; locked<=1.
- LOCKED, accepted sample with sync=0:
  - Stored to shadow[slot]; slot<=slot+1, wrapping 3->0.
- LOCKED, accepted sample with sync=1 and slot!=0 (early sync):
  - sync_err pulses next cycle and the partial frame is discarded.
  - The sample is stored as shadow[0]; slot<=1; state stays LOCKED.
- LOCKED, accepted sample with sync=1 and slot==0:
  - Normal slot-0 store; slot<=1.
- LOCKED, accepted sample with sync=0 and slot==0:
  - Behaviour depends on the optional feature (see Optional Feature).
- Frame completion (accepted sample at slot 3, no early sync):
  - At that same edge, w <= {din, shadow[2], shadow[1], shadow[0]} (channel 3 is the incoming din).
  - frame_valid=1 for exactly the following cycle.
  - Latency: 1 edge from the slot-3 sample to the w update.
- w holds its value between frames; frame_valid is never asserted on partial frames.
- Back-to-back frames with din_valid held high produce a frame_valid pulse every 4th cycle.
- sync_err and frame_valid are never high in the same cycle. An early sync at slot 3 is an error, not a completion.
- Implementation: 2-state FSM (HUNT, LOCKED), 2-bit slot counter, 3 shadow registers, registered outputs.

Optional Feature:
- Macro: TDM_DEMUX_SYNC_CHECK_EN.
- Defined (strict sync): in LOCKED, an accepted sample at slot 0 with sync=0 is a lost-sync event.
  - sync_err pulses next cycle and the sample is dropped.
  - state<=HUNT, locked<=0, slot<=0.
- Undefined (sync needed only to acquire lock): that sample is accepted as slot 0 normally and no error is raised.
- Early-sync handling is identical in both builds.

Test Plan:
- Reset, then a 4-sample burst 1,0,1,1 with no sync -> locked=0, w=0, frame_valid never asserts.
- WIDTH=4: sync+A, 5, C, 3 on consecutive cycles -> the cycle after the 4th sample, w=16'h3C5A, frame_valid=1 for 1 cycle, slot=0, locked=1.
- Same frame with din_valid deasserted for 2 cycles between slots 1 and 2 -> identical w=16'h3C5A; frame_valid pulses 1 cycle after the last sample.
- Locked, slot=2, sample 7 with sync=1 -> sync_err pulse, no frame_valid, slot=1; next 3 samples 1,2,3 -> w=16'h3217.
- TDM_DEMUX_SYNC_CHECK_EN defined: after one good frame, next slot-0 sample arrives with sync=0 -> sync_err pulse, locked=0, w unchanged. Same stimulus with the macro undefined -> no error; frame completes normally.
- Assert rst asynchronously mid-frame at slot 2 -> all outputs 0 immediately; a following 3 samples produce no frame_valid until a sync is seen.
